// File: rtl/i8251_rx_if.sv
// Bus-side connection of the 8251 receiver: mode/command fields and strobes in,
// holding register and status flags out.
interface i8251_rx_if;
  logic       rx_en;
  logic [1:0] baud_factor;
  logic [1:0] char_len;
  logic       parity_en;
  logic       parity_even;
  logic       rd_data;
  logic       err_reset;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       pe;
  logic       oe;
  logic       fe;
  logic       brk_det;
  logic       busy;

  modport master (
    output rx_en, baud_factor, char_len, parity_en, parity_even, rd_data, err_reset,
    input  rx_data, rx_rdy, pe, oe, fe, brk_det, busy
  );

  modport slave (
    input  rx_en, baud_factor, char_len, parity_en, parity_even, rd_data, err_reset,
    output rx_data, rx_rdy, pe, oe, fe, brk_det, busy
  );
endinterface

// File: rtl/i8251_rx.sv
// 8251-compatible asynchronous receiver: start/data/parity/stop deframing on
// receiver-clock ticks, holding register with RxRDY and PE/OE/FE/break status.
module i8251_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rxc_tick,
  input  logic      rxd,
  i8251_rx_if.slave bus
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_err(input logic [7:0] data, input logic pbit, input logic even);
    return (^data) ^ pbit ^ ~even;
  endfunction

  function automatic logic [7:0] char_mask(input logic [1:0] len);
    case (len)
      2'b00:   return 8'h1F;
      2'b01:   return 8'h3F;
      2'b10:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  logic [SYNC_N-1:0] sync_r;
  state_t            state_r, state_s;
  logic [5:0]        cnt_r, cnt_s;
  logic [2:0]        bit_r, bit_s;
  logic [7:0]        shift_r, shift_s;
  logic              armed_r, armed_s;
  logic              pe_pend_r, pe_pend_s;
  logic              par_bit_r, par_bit_s;
  logic              stop_r, stop_s;
  logic              zero_r, zero_s;
  logic              load_r, load_s;
  logic              busy_r;
  logic              idle_high_s;
  logic              line_s;
  logic [5:0]        period_last_s;
  logic [5:0]        half_s;
  logic [2:0]        last_bit_s;
  logic              sample_s;
  logic [7:0]        rx_data_r;
  logic              rx_rdy_r, pe_r, oe_r, fe_r, brk_r, brk_seen_r;

  assign line_s     = sync_r[SYNC_N-1];
  assign last_bit_s = 3'd4 + {1'b0, bus.char_len};
  assign sample_s   = (cnt_r == period_last_s);

  // Bit period minus one and half period per baud factor (sync mode falls back to 1x).
  always_comb begin
    period_last_s = 6'd0;
    half_s        = 6'd0;
    case (bus.baud_factor)
      2'b10: begin
        period_last_s = 6'd15;
        half_s        = 6'd8;
      end
      2'b11: begin
        period_last_s = 6'd63;
        half_s        = 6'd32;
      end
      default: begin
        period_last_s = 6'd0;
        half_s        = 6'd0;
      end
    endcase
  end

  // Receive FSM next-state logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    armed_s     = armed_r;
    pe_pend_s   = pe_pend_r;
    par_bit_s   = par_bit_r;
    stop_s      = stop_r;
    zero_s      = zero_r;
    load_s      = 1'b0;
    idle_high_s = 1'b0;
    if (!bus.rx_en && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
      cnt_s   = 6'd0;
      bit_s   = 3'd0;
    end else if (rxc_tick) begin
      case (state_r)
        ST_IDLE: begin
          if (line_s) begin
            armed_s     = 1'b1;
            idle_high_s = 1'b1;
          end else if (armed_r && bus.rx_en) begin
            armed_s   = 1'b0;
            cnt_s     = 6'd0;
            bit_s     = 3'd0;
            shift_s   = 8'd0;
            pe_pend_s = 1'b0;
            par_bit_s = 1'b0;
            // At 1x there is no mid-bit to find: the next tick is data bit 0.
            state_s   = (period_last_s == 6'd0) ? ST_DATA : ST_START;
          end else begin
            armed_s = armed_r;
          end
        end
        ST_START: begin
          if (cnt_r == half_s - 6'd1) begin
            cnt_s = 6'd0;
            if (line_s) begin
              state_s = ST_IDLE;
              armed_s = 1'b0;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            cnt_s = cnt_r + 6'd1;
          end
        end
        ST_DATA: begin
          if (sample_s) begin
            cnt_s          = 6'd0;
            shift_s[bit_r] = line_s;
            if (bit_r == last_bit_s) begin
              bit_s   = 3'd0;
              state_s = bus.parity_en ? ST_PARITY : ST_STOP;
            end else begin
              bit_s = bit_r + 3'd1;
            end
          end else begin
            cnt_s = cnt_r + 6'd1;
          end
        end
        ST_PARITY: begin
          if (sample_s) begin
            cnt_s     = 6'd0;
            par_bit_s = line_s;
            pe_pend_s = parity_err(shift_r, line_s, bus.parity_even);
            state_s   = ST_STOP;
          end else begin
            cnt_s = cnt_r + 6'd1;
          end
        end
        ST_STOP: begin
          if (sample_s) begin
            cnt_s   = 6'd0;
            stop_s  = line_s;
            zero_s  = (shift_r == 8'd0) && !(bus.parity_en && par_bit_r) && !line_s;
            load_s  = 1'b1;
            // A break frame re-arms so a line held low keeps being framed.
            armed_s = line_s | zero_s;
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_r + 6'd1;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // rxd synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_N{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_N-2:0], rxd};
    end
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 6'd0;
      bit_r     <= 3'd0;
      shift_r   <= 8'd0;
      armed_r   <= 1'b0;
      pe_pend_r <= 1'b0;
      par_bit_r <= 1'b0;
      stop_r    <= 1'b0;
      zero_r    <= 1'b0;
      load_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      armed_r   <= armed_s;
      pe_pend_r <= pe_pend_s;
      par_bit_r <= par_bit_s;
      stop_r    <= stop_s;
      zero_r    <= zero_s;
      load_r    <= load_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  // Holding register, RxRDY and status flags; set events beat clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_r  <= 8'd0;
      rx_rdy_r   <= 1'b0;
      pe_r       <= 1'b0;
      oe_r       <= 1'b0;
      fe_r       <= 1'b0;
      brk_r      <= 1'b0;
      brk_seen_r <= 1'b0;
    end else begin
      if (load_r) begin
        rx_data_r <= shift_r & char_mask(bus.char_len);
        rx_rdy_r  <= 1'b1;
      end else if (bus.rd_data) begin
        rx_rdy_r <= 1'b0;
      end
      if (load_r && rx_rdy_r && !bus.rd_data) begin
        oe_r <= 1'b1;
      end else if (bus.err_reset) begin
        oe_r <= 1'b0;
      end
      if (load_r && pe_pend_r) begin
        pe_r <= 1'b1;
      end else if (bus.err_reset) begin
        pe_r <= 1'b0;
      end
      if (load_r && !stop_r) begin
        fe_r <= 1'b1;
      end else if (bus.err_reset) begin
        fe_r <= 1'b0;
      end
      if (load_r) begin
        brk_seen_r <= zero_r;
        brk_r      <= zero_r && (brk_seen_r || brk_r);
      end else if (idle_high_s) begin
        brk_seen_r <= 1'b0;
        brk_r      <= 1'b0;
      end
    end
  end

  assign bus.rx_data = rx_data_r;
  assign bus.rx_rdy  = rx_rdy_r;
  assign bus.pe      = pe_r;
  assign bus.oe      = oe_r;
  assign bus.fe      = fe_r;
  assign bus.brk_det = brk_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_i8251_rx.sv
// Self-checking bench for i8251_rx: directed vector table, hand-built corner
// sequences and randomized frames against a frame-level reference model.
module tb_i8251_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxc_tick = 1'b0;
  logic rxd = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  i8251_rx_if rx_bus();

  i8251_rx #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .rxc_tick (rxc_tick),
    .rxd      (rxd),
    .bus      (rx_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] baud;
    logic [1:0] clen;
    logic       pen;
    logic       peven;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       rd_after;
    logic       er_after;
    logic       chk_lat;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_oe;
    logic       exp_fe;
  } vec_t;

  vec_t       vecs[10];
  logic [1:0] cur_baud = 2'b00;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nper(input logic [1:0] b);
    if (b == 2'b10) return 16;
    else if (b == 2'b11) return 64;
    else return 1;
  endfunction

  // One receiver-clock tick; rxd has three clk edges to settle through the synchroniser.
  task automatic tick1();
    repeat (3) @(negedge clk);
    rxc_tick = 1'b1;
    @(negedge clk);
    rxc_tick = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] b, input logic [1:0] cl, input logic pen, input logic pev);
    rx_bus.rx_en = 1'b0;
    @(negedge clk);
    rx_bus.baud_factor = b;
    rx_bus.char_len    = cl;
    rx_bus.parity_en   = pen;
    rx_bus.parity_even = pev;
    cur_baud           = b;
    @(negedge clk);
    rx_bus.rx_en = 1'b1;
  endtask

  task automatic strobe_rd();
    @(negedge clk) rx_bus.rd_data = 1'b1;
    @(negedge clk) rx_bus.rd_data = 1'b0;
  endtask

  task automatic strobe_er();
    @(negedge clk) rx_bus.err_reset = 1'b1;
    @(negedge clk) rx_bus.err_reset = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen, input logic pb,
                            input logic stop, input logic rd_at_load, input logic chk_lat);
    int n;
    int h;
    n = nper(cur_baud);
    h = n / 2;
    rxd = 1'b0;
    repeat (n) tick1();
    for (int k = 0; k < nb; k++) begin
      rxd = d[k];
      repeat (n) tick1();
    end
    if (pen) begin
      rxd = pb;
      repeat (n) tick1();
    end
    rxd = stop;
    repeat (h) tick1();
    repeat (3) @(negedge clk);
    rxc_tick = 1'b1;
    @(negedge clk);
    rxc_tick = 1'b0;
    if (rd_at_load) rx_bus.rd_data = 1'b1;
    if (chk_lat) check("rdy_before_load", {7'd0, rx_bus.rx_rdy}, 8'd0);
    @(negedge clk);
    rx_bus.rd_data = 1'b0;
    if (chk_lat) check("rdy_one_clk_after_stop", {7'd0, rx_bus.rx_rdy}, 8'd1);
    repeat (n - h - 1) tick1();
    rxd = 1'b1;
    repeat (3) tick1();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, rx_bus.rx_data, 8'd0);
    check({tag, "_rdy"},  {7'd0, rx_bus.rx_rdy}, 8'd0);
    check({tag, "_pe"},   {7'd0, rx_bus.pe}, 8'd0);
    check({tag, "_oe"},   {7'd0, rx_bus.oe}, 8'd0);
    check({tag, "_fe"},   {7'd0, rx_bus.fe}, 8'd0);
    check({tag, "_brk"},  {7'd0, rx_bus.brk_det}, 8'd0);
    check({tag, "_busy"}, {7'd0, rx_bus.busy}, 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] m_data;
    logic       m_rdy, m_pe, m_oe, m_fe;
    logic [1:0] b, cl;
    logic       pen, pev, pb, stp, rd, er;
    logic [7:0] d;
    int         nb, masked;

    // baud clen pen even data pbit stop rd er lat | data pe oe fe
    vecs[0] = '{2'b10, 2'b11, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 2'b10, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 2'b11, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 2'b11, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2'b10, 2'b00, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{2'b01, 2'b01, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b00, 2'b11, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{2'b10, 2'b01, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{2'b10, 2'b11, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};

    rx_bus.rx_en = 1'b0;
    rx_bus.baud_factor = 2'b00;
    rx_bus.char_len = 2'b11;
    rx_bus.parity_en = 1'b0;
    rx_bus.parity_even = 1'b0;
    rx_bus.rd_data = 1'b0;
    rx_bus.err_reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    rx_bus.rx_en = 1'b1;
    repeat (3) tick1();

    for (int i = 0; i < 10; i++) begin
      set_mode(vecs[i].baud, vecs[i].clen, vecs[i].pen, vecs[i].peven);
      send_frame(vecs[i].data, 5 + int'(vecs[i].clen), vecs[i].pen, vecs[i].pbit, vecs[i].stop,
                 1'b0, vecs[i].chk_lat);
      check($sformatf("v%0d_data", i), rx_bus.rx_data, vecs[i].exp_data);
      check($sformatf("v%0d_rdy", i), {7'd0, rx_bus.rx_rdy}, 8'd1);
      check($sformatf("v%0d_pe", i), {7'd0, rx_bus.pe}, {7'd0, vecs[i].exp_pe});
      check($sformatf("v%0d_oe", i), {7'd0, rx_bus.oe}, {7'd0, vecs[i].exp_oe});
      check($sformatf("v%0d_fe", i), {7'd0, rx_bus.fe}, {7'd0, vecs[i].exp_fe});
      if (vecs[i].rd_after) strobe_rd();
      if (vecs[i].er_after) strobe_er();
      @(negedge clk);
      check($sformatf("v%0d_rdy_after", i), {7'd0, rx_bus.rx_rdy}, {7'd0, !vecs[i].rd_after});
      check($sformatf("v%0d_pe_after", i), {7'd0, rx_bus.pe}, {7'd0, vecs[i].exp_pe & !vecs[i].er_after});
      check($sformatf("v%0d_fe_after", i), {7'd0, rx_bus.fe}, {7'd0, vecs[i].exp_fe & !vecs[i].er_after});
      check($sformatf("v%0d_data_after", i), rx_bus.rx_data, vecs[i].exp_data);
    end

    // Read strobe coincident with the second load: no overrun, RxRDY stays set.
    set_mode(2'b11, 2'b11, 1'b0, 1'b0);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("coinc_data", rx_bus.rx_data, 8'h34);
    check("coinc_rdy", {7'd0, rx_bus.rx_rdy}, 8'd1);
    check("coinc_oe", {7'd0, rx_bus.oe}, 8'd0);
    strobe_rd();

    // False start, then a 5-bit frame.
    set_mode(2'b10, 2'b11, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (4) tick1();
    check("fstart_busy_mid", {7'd0, rx_bus.busy}, 8'd1);
    rxd = 1'b1;
    repeat (10) tick1();
    check("fstart_busy_end", {7'd0, rx_bus.busy}, 8'd0);
    check("fstart_no_load", {7'd0, rx_bus.rx_rdy}, 8'd0);
    set_mode(2'b10, 2'b00, 1'b0, 1'b0);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fstart_next_data", rx_bus.rx_data, 8'h1F);
    strobe_rd();

    // Line held low for three 16x 8N1 frame times: frames end at ticks 152, 305, 458.
    set_mode(2'b10, 2'b11, 1'b0, 1'b0);
    rxd = 1'b0;
    for (int t = 0; t < 459; t++) begin
      tick1();
      if (t == 153) begin
        check("brk_f1_data", rx_bus.rx_data, 8'h00);
        check("brk_f1_fe", {7'd0, rx_bus.fe}, 8'd1);
        check("brk_f1_brk", {7'd0, rx_bus.brk_det}, 8'd0);
      end
      if (t == 306) check("brk_f2_brk", {7'd0, rx_bus.brk_det}, 8'd1);
      if (t == 457) check("brk_f3_brk", {7'd0, rx_bus.brk_det}, 8'd1);
    end
    rxd = 1'b1;
    tick1();
    check("brk_clear", {7'd0, rx_bus.brk_det}, 8'd0);
    strobe_rd();
    strobe_er();

    // Dropping RxE mid-frame discards the partial character.
    rxd = 1'b0;
    repeat (20) tick1();
    rxd = 1'b1;
    repeat (16) tick1();
    check("rxen_busy_before", {7'd0, rx_bus.busy}, 8'd1);
    @(negedge clk) rx_bus.rx_en = 1'b0;
    @(negedge clk);
    check("rxen_busy_after", {7'd0, rx_bus.busy}, 8'd0);
    repeat (200) tick1();
    check("rxen_no_load", {7'd0, rx_bus.rx_rdy}, 8'd0);
    check("rxen_data_kept", rx_bus.rx_data, 8'h00);
    rx_bus.rx_en = 1'b1;

    // 1x 6N1, then reset in the middle of bit 3 of a second frame.
    set_mode(2'b01, 2'b01, 1'b0, 1'b0);
    send_frame(8'h2A, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("x1_data", rx_bus.rx_data, 8'h2A);
    d = 8'h2D;
    rxd = 1'b0;
    tick1();
    for (int k = 0; k < 3; k++) begin
      rxd = d[k];
      tick1();
    end
    rxd = d[3];
    check("rst_mid_busy", {7'd0, rx_bus.busy}, 8'd1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    reset = 1'b0;
    rxd = 1'b1;
    repeat (3) tick1();
    send_frame(8'h15, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_data", rx_bus.rx_data, 8'h15);
    check("post_rst_rdy", {7'd0, rx_bus.rx_rdy}, 8'd1);
    check("post_rst_oe", {7'd0, rx_bus.oe}, 8'd0);
    strobe_rd();
    strobe_er();

    // Randomized frames against a frame-level model of the holding register and flags.
    m_data = 8'h15;
    m_rdy = 1'b0;
    m_pe = 1'b0;
    m_oe = 1'b0;
    m_fe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b   = 2'($urandom_range(0, 3));
      cl  = 2'($urandom_range(0, 3));
      pen = 1'($urandom_range(0, 1));
      pev = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) != 0);
      rd  = 1'($urandom_range(0, 1));
      er  = 1'($urandom_range(0, 1));
      nb  = 5 + int'(cl);
      set_mode(b, cl, pen, pev);
      send_frame(d, nb, pen, pb, stp, 1'b0, 1'b0);
      masked = int'(d) % (1 << nb);
      if (m_rdy) m_oe = 1'b1;
      m_rdy  = 1'b1;
      m_data = 8'(masked);
      if (pen && ((($countones(8'(masked)) + int'(pb)) % 2) != (pev ? 0 : 1))) m_pe = 1'b1;
      if (!stp) m_fe = 1'b1;
      check($sformatf("r%0d_data", i), rx_bus.rx_data, m_data);
      check($sformatf("r%0d_rdy", i), {7'd0, rx_bus.rx_rdy}, {7'd0, m_rdy});
      check($sformatf("r%0d_pe", i), {7'd0, rx_bus.pe}, {7'd0, m_pe});
      check($sformatf("r%0d_oe", i), {7'd0, rx_bus.oe}, {7'd0, m_oe});
      check($sformatf("r%0d_fe", i), {7'd0, rx_bus.fe}, {7'd0, m_fe});
      check($sformatf("r%0d_brk", i), {7'd0, rx_bus.brk_det}, 8'd0);
      check($sformatf("r%0d_busy", i), {7'd0, rx_bus.busy}, 8'd0);
      if (rd) begin
        strobe_rd();
        m_rdy = 1'b0;
      end
      if (er) begin
        strobe_er();
        m_pe = 1'b0;
        m_oe = 1'b0;
        m_fe = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
